multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the RV32I subset datapath: owns the instruction/data memory handshake, steps each instruction through fetch, decode, execute, memory and writeback, and drives the pc, register file, ALU and writeback muxes. It sits beside the datapath registers (pc, IR, register file, ALU) and is the only block that asserts their write enables.

## Interface
- TIMEOUT_CYCLES, 15: memory wait limit in cycles; 0 disables the timeout.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ir  in  32  instruction register contents (datapath IR)
- zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request (fetch or data)
- mem_we  out  1  store request; valid only with mem_req
- addr_sel  out  1  0 = pc drives address, 1 = ALU result
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  load pc
- pc_src  out  1  0 = pc+4, 1 = branch target
- reg_write  out  1  register file write_enable
- wb_sel  out  1  0 = ALU result, 1 = memory data
- alu_src_b  out  1  0 = rs2, 1 = sign-extended immediate
- alu_op  out  3  ALU operation code
- halted  out  1  sticky; controller stopped
- illegal  out  1  sticky; halt caused by undecodable instruction
- bus_err  out  1  sticky; halt caused by memory timeout

## Operation
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, HALT. Moore outputs decoded from state plus latched decode fields.
- RESET: all outputs 0; unconditionally → FETCH next cycle.
- FETCH: mem_req=1, mem_we=0, addr_sel=0; on mem_ready: ir_write=1 that cycle, → DECODE.
- DECODE: classify ir[6:0]: 0110011 R, 0010011 I-ALU, 0000011 LW (funct3 010), 0100011 SW (funct3 010), 1100011 BEQ (funct3 000), 1110011 ECALL → HALT (illegal=0). Anything else → HALT with illegal=1.
- ALU mapping (funct3): 000 ADD (SUB when R and ir[30]=1), 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRL, 010 SLT. R with ir[30]=1 on non-000, 101 with ir[30]=1, or 011 → illegal.
- EXEC: alu_op as decoded; alu_src_b=1 for I/LW/SW. LW/SW use ADD → MEM. R/I → WB. BEQ: alu_op=SUB, alu_src_b=0, pc_write=1, pc_src=zero, → FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for SW. On mem_ready: SW asserts pc_write=1, pc_src=0, → FETCH; LW → WB.
- WB: reg_write=1, wb_sel=1 for LW else 0, pc_write=1, pc_src=0, → FETCH.
- HALT: terminal until reset; all strobes 0, halted=1.
- Timeout: counter of consecutive cycles with mem_req=1 and mem_ready=0; on reaching TIMEOUT_CYCLES → HALT with bus_err=1, no strobe issued.

## Timing
- Zero-wait latency (cycles, FETCH to next FETCH): R/I 4, LW 5, SW 4, BEQ 3; each memory wait cycle adds 1.
- Handshake: mem_req held with stable addr_sel/mem_we until mem_ready sampled high on a rising edge; mem_req drops the following cycle (next state). mem_ready while mem_req=0 ignored.
- ir_write, pc_write, reg_write are single-cycle pulses; never two pc_write in one instruction.
- Reset asserted mid-instruction: state → RESET immediately, all outputs 0 asynchronously, in-flight request abandoned; sticky flags cleared.
- Timeout counter clears on every state change; mem_ready on the same cycle the count hits the limit wins (transaction completes).
- rd=x0 handled by register file; controller still pulses reg_write.

## Structure
- Shared package cpu_pkg: alu_op enum (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SLT=7), opcode constants, ctrl_state_t enum.
- Sub-module ctrl_decode: combinational ir → {instruction class, alu_op, alu_src_b, illegal}; latched into the controller at DECODE.

## Test plan
- Reset then ir=0x00208133 (add x2,x1,x2), mem_ready always 1 -> FETCH/DECODE/EXEC/WB in 4 cycles, alu_op=0, reg_write and pc_write pulse in WB with pc_src=0.
- ir=0x0000A103 (lw x2,0(x1)), mem_ready low 3 cycles in MEM -> mem_req=1, addr_sel=1 held 4 cycles, then WB with wb_sel=1; total 8 cycles.
- ir=0x00208463 (beq) with zero=1, then zero=0 -> EXEC pc_write=1, pc_src=1 / pc_src=0; 3 cycles each; alu_op=1.
- ir=0x4020D133 (sra) -> DECODE → HALT, illegal=1, halted=1, no reg_write; ir=0x00000073 -> halted=1, illegal=0.
- TIMEOUT_CYCLES=15, mem_ready held 0 in FETCH -> after 15 cycles HALT, bus_err=1, mem_req=0; mem_ready=1 on 15th cycle instead -> normal ir_write.
- rst_n dropped during MEM of sw -> mem_req falls without clock edge; after release, RESET one cycle then FETCH with mem_we=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the multi-cycle RV32I subset controller: ALU codes, opcodes,
// controller states and the decoded-instruction payload.
package cpu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_t;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_SYS = 7'b1110011;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } ctrl_state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_ECALL,
        CLS_ILLEGAL
    } instr_class_t;

    typedef struct packed {
        instr_class_t cls;
        alu_op_t      alu_op;
        logic         alu_src_b;
        logic         illegal;
    } decode_t;

    // funct3 -> ALU operation; sub selects SUB over ADD for funct3 000
    function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3, input logic sub);
        alu_op_t op;
        case (funct3)
            3'b000:  op = sub ? ALU_SUB : ALU_ADD;
            3'b111:  op = ALU_AND;
            3'b110:  op = ALU_OR;
            3'b100:  op = ALU_XOR;
            3'b001:  op = ALU_SLL;
            3'b101:  op = ALU_SRL;
            3'b010:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: ir -> class, ALU operation, operand-B
// select and illegal flag.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [31:0] ir,
    output decode_t     dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       bit30;
    logic       unused_ir;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign bit30     = ir[30];
    assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

    always_comb begin
        dec = '{cls: CLS_ILLEGAL, alu_op: ALU_ADD, alu_src_b: 1'b0, illegal: 1'b1};
        case (opcode)
            OPC_R: begin
                // bit 30 only legal as the SUB selector
                if (funct3 != 3'b011 && !(bit30 && funct3 != 3'b000)) begin
                    dec = '{cls: CLS_R, alu_op: alu_from_funct3(funct3, bit30),
                            alu_src_b: 1'b0, illegal: 1'b0};
                end
            end
            OPC_I: begin
                if (funct3 != 3'b011 && !(bit30 && funct3 == 3'b101)) begin
                    dec = '{cls: CLS_I, alu_op: alu_from_funct3(funct3, 1'b0),
                            alu_src_b: 1'b1, illegal: 1'b0};
                end
            end
            OPC_LW: begin
                if (funct3 == 3'b010) begin
                    dec = '{cls: CLS_LW, alu_op: ALU_ADD, alu_src_b: 1'b1, illegal: 1'b0};
                end
            end
            OPC_SW: begin
                if (funct3 == 3'b010) begin
                    dec = '{cls: CLS_SW, alu_op: ALU_ADD, alu_src_b: 1'b1, illegal: 1'b0};
                end
            end
            OPC_BEQ: begin
                if (funct3 == 3'b000) begin
                    dec = '{cls: CLS_BEQ, alu_op: ALU_SUB, alu_src_b: 1'b0, illegal: 1'b0};
                end
            end
            OPC_SYS: begin
                dec = '{cls: CLS_ECALL, alu_op: ALU_ADD, alu_src_b: 1'b0, illegal: 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32I subset datapath: memory handshake,
// fetch/decode/execute/memory/writeback stepping and all datapath strobes.
module multicycle_control
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic        wb_sel,
    output logic        alu_src_b,
    output logic [2:0]  alu_op,
    output logic        halted,
    output logic        illegal,
    output logic        bus_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    ctrl_state_t  state_q, state_d;
    decode_t      dec;
    instr_class_t cls_q;
    alu_op_t      alu_op_q;
    logic         alu_src_b_q;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic         illegal_q, illegal_d;
    logic         bus_err_q, bus_err_d;
    logic         wait_hit;

    ctrl_decode u_decode (
        .ir  (ir),
        .dec (dec)
    );

    // The cycle that would make the wait count reach the limit aborts, unless mem_ready wins
    assign wait_hit = (TIMEOUT_CYCLES != 0) && (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // State, latched decode fields, wait counter and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            cls_q       <= CLS_ILLEGAL;
            alu_op_q    <= ALU_ADD;
            alu_src_b_q <= 1'b0;
            wait_q      <= '0;
            illegal_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            if (state_q == ST_DECODE) begin
                cls_q       <= dec.cls;
                alu_op_q    <= dec.alu_op;
                alu_src_b_q <= dec.alu_src_b;
            end
        end
    end

    // Next state and Moore-style strobes from state plus latched decode
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = '0;

        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (wait_hit) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                if (dec.illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else if (dec.cls == CLS_ECALL) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op    = alu_op_q;
                alu_src_b = alu_src_b_q;
                case (cls_q)
                    CLS_LW, CLS_SW: state_d = ST_MEM;
                    CLS_BEQ: begin
                        pc_write = 1'b1;
                        pc_src   = zero;
                        state_d  = ST_FETCH;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                alu_op    = alu_op_q;
                alu_src_b = alu_src_b_q;
                mem_req   = 1'b1;
                addr_sel  = 1'b1;
                mem_we    = (cls_q == CLS_SW);
                if (mem_ready) begin
                    if (cls_q == CLS_SW) begin
                        pc_write = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_hit) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            ST_WB: begin
                alu_op    = alu_op_q;
                alu_src_b = alu_src_b_q;
                reg_write = 1'b1;
                wb_sel    = (cls_q == CLS_LW);
                pc_write  = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_HALT: ;
            default: state_d = ST_RESET;
        endcase
    end

    assign halted  = (state_q == ST_HALT);
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: a per-instruction phase
// model plans input vectors and expected control words; a monitor compares each cycle.
module tb_multicycle_control;

    localparam int unsigned TO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ir = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src;
    logic        reg_write, wb_sel, alu_src_b, halted, illegal, bus_err;
    logic [2:0]  alu_op;

    multicycle_control #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir        (ir),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .wb_sel    (wb_sel),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .halted    (halted),
        .illegal   (illegal),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_ECALL, K_ILL} kind_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic       wb_sel;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic       halted;
        logic       illegal;
        logic       bus_err;
        logic       care_alu;
    } exp_t;

    exp_t exq[$];
    exp_t pl_e[$];
    logic pl_mr[$];
    logic pl_z[$];
    logic pl_rst[$];

    int checks = 0;
    int failures = 0;
    int cyc_no = 0;
    bit mon_en = 1'b0;

    // Blank fields the specification leaves free in the expected word r
    function automatic exp_t masked(input exp_t v, input exp_t r);
        exp_t m = v;
        if (!r.mem_req) begin
            m.addr_sel = 1'b0;
            m.mem_we   = 1'b0;
        end
        if (!r.pc_write)  m.pc_src = 1'b0;
        if (!r.reg_write) m.wb_sel = 1'b0;
        if (!r.care_alu) begin
            m.alu_op    = 3'd0;
            m.alu_src_b = 1'b0;
        end
        m.care_alu = 1'b0;
        return m;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t a;
        exp_t x;
        if (mon_en) begin
            checks++;
            if (exq.size() == 0) begin
                failures++;
                $display("FAIL cycle %0d underflow: DUT cycle with no expected control word", cyc_no);
            end else begin
                x = exq.pop_front();
                a = '0;
                a.mem_req = mem_req;   a.mem_we = mem_we;     a.addr_sel = addr_sel;
                a.ir_write = ir_write; a.pc_write = pc_write; a.pc_src = pc_src;
                a.reg_write = reg_write; a.wb_sel = wb_sel;   a.alu_src_b = alu_src_b;
                a.alu_op = alu_op;     a.halted = halted;     a.illegal = illegal;
                a.bus_err = bus_err;
                if (masked(a, x) != masked(x, x)) begin
                    failures++;
                    $display("FAIL cycle %0d ctrl {req,we,asel,irw,pcw,pcsrc,regw,wbsel,srcb,aluop,halt,ill,berr,-}: got %b want %b",
                             cyc_no, masked(a, x), masked(x, x));
                end
            end
            cyc_no++;
        end
    end

    task automatic cyc(input exp_t e, input int mr, input int z, input logic rst);
        pl_e.push_back(e);
        pl_mr.push_back(mr == 2 ? 1'($urandom_range(0, 1)) : 1'(mr));
        pl_z.push_back(z == 2 ? 1'($urandom_range(0, 1)) : 1'(z));
        pl_rst.push_back(rst);
    endtask

    // Memory phase: w wait cycles, then completion word fin; w >= TO means timeout
    task automatic mem_phase(input logic asel, input logic we, input int w, input exp_t fin,
                             output bit to);
        exp_t e = '0;
        e.mem_req  = 1'b1;
        e.addr_sel = asel;
        e.mem_we   = we;
        to = (TO != 0) && (w >= int'(TO));
        repeat (to ? int'(TO) : w) cyc(e, 0, 2, 1'b1);
        if (!to) begin
            fin.mem_req  = 1'b1;
            fin.addr_sel = asel;
            fin.mem_we   = we;
            cyc(fin, 1, 2, 1'b1);
        end
    endtask

    task automatic halt_seq(input logic ill, input logic be);
        exp_t e = '0;
        e.halted  = 1'b1;
        e.illegal = ill;
        e.bus_err = be;
        repeat ($urandom_range(1, 3)) cyc(e, 2, 2, 1'b1);
    endtask

    // rst_n low 1-2 cycles, then exactly one RESET cycle before the next fetch
    task automatic reset_seq();
        exp_t e = '0;
        repeat ($urandom_range(1, 2)) cyc(e, 2, 2, 1'b0);
        cyc(e, 2, 2, 1'b1);
    endtask

    function automatic exp_t exe(input logic [2:0] op, input logic srcb);
        exp_t e = '0;
        e.care_alu  = 1'b1;
        e.alu_op    = op;
        e.alu_src_b = srcb;
        return e;
    endfunction

    // One instruction as phases: FETCH, DECODE, then class-specific tail
    task automatic plan(input kind_e k, input logic [2:0] op, input int wf, input int wm,
                        input logic zex, input int abort_at);
        exp_t e;
        bit   to;
        bit   hlt = 1'b0;
        int   p;
        pl_e.delete(); pl_mr.delete(); pl_z.delete(); pl_rst.delete();
        e = '0;
        e.ir_write = 1'b1;
        mem_phase(1'b0, 1'b0, wf, e, to);
        if (to) begin
            halt_seq(1'b0, 1'b1);
            hlt = 1'b1;
        end else begin
            e = '0;
            cyc(e, 2, 2, 1'b1);
            case (k)
                K_ECALL: begin halt_seq(1'b0, 1'b0); hlt = 1'b1; end
                K_ILL:   begin halt_seq(1'b1, 1'b0); hlt = 1'b1; end
                K_BEQ: begin
                    e = exe(3'd1, 1'b0);
                    e.pc_write = 1'b1;
                    e.pc_src   = zex;
                    cyc(e, 2, int'(zex), 1'b1);
                end
                K_R, K_I: begin
                    cyc(exe(op, k == K_I), 2, 2, 1'b1);
                    e = '0;
                    e.reg_write = 1'b1;
                    e.pc_write  = 1'b1;
                    cyc(e, 2, 2, 1'b1);
                end
                K_LW: begin
                    cyc(exe(3'd0, 1'b1), 2, 2, 1'b1);
                    e = '0;
                    mem_phase(1'b1, 1'b0, wm, e, to);
                    if (to) begin
                        halt_seq(1'b0, 1'b1);
                        hlt = 1'b1;
                    end else begin
                        e = '0;
                        e.reg_write = 1'b1;
                        e.wb_sel    = 1'b1;
                        e.pc_write  = 1'b1;
                        cyc(e, 2, 2, 1'b1);
                    end
                end
                default: begin
                    cyc(exe(3'd0, 1'b1), 2, 2, 1'b1);
                    e = '0;
                    e.pc_write = 1'b1;
                    mem_phase(1'b1, 1'b1, wm, e, to);
                    if (to) begin
                        halt_seq(1'b0, 1'b1);
                        hlt = 1'b1;
                    end
                end
            endcase
        end
        if (!hlt && abort_at >= 0) begin
            p = (abort_at == 0) ? int'($urandom_range(1, pl_e.size() - 1)) : abort_at;
            pl_e = pl_e[0:p-1]; pl_mr = pl_mr[0:p-1];
            pl_z = pl_z[0:p-1]; pl_rst = pl_rst[0:p-1];
        end
        if (hlt || abort_at >= 0) reset_seq();
    endtask

    task automatic play(input logic [31:0] iw);
        foreach (pl_e[i]) exq.push_back(pl_e[i]);
        for (int i = 0; i < pl_e.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n     = pl_rst[i];
            mem_ready = pl_mr[i];
            zero      = pl_z[i];
            ir        = iw;
            mon_en    = 1'b1;
        end
    endtask

    function automatic logic [2:0] f3_of(input logic [2:0] op);
        case (op)
            3'd2:    return 3'b111;
            3'd3:    return 3'b110;
            3'd4:    return 3'b100;
            3'd5:    return 3'b001;
            3'd6:    return 3'b101;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int pick_wait();
        int r = int'($urandom_range(0, 15));
        if (r < 9)   return 0;
        if (r < 13)  return int'($urandom_range(1, 3));
        if (r == 13) return int'(TO) - 1;
        return int'(TO) + int'($urandom_range(0, 2));
    endfunction

    task automatic gen(output logic [31:0] iw, output kind_e k, output logic [2:0] op);
        logic [31:0] r = $urandom;
        logic [2:0]  f3;
        logic [6:0]  o;
        int          s = int'($urandom_range(0, 99));
        op = 3'd0;
        if (s < 30) begin
            k  = K_R;
            op = 3'($urandom_range(0, 7));
            iw = {1'b0, op == 3'd1, 5'b0, r[24:15], f3_of(op), r[11:7], 7'b0110011};
        end else if (s < 50) begin
            k  = K_I;
            op = 3'($urandom_range(0, 6));
            if (op != 3'd0) op = op + 3'd1;
            iw = {r[31:15], f3_of(op), r[11:7], 7'b0010011};
            if (op == 3'd6) iw[30] = 1'b0;
        end else if (s < 62) begin
            k  = K_LW;
            iw = {r[31:15], 3'b010, r[11:7], 7'b0000011};
        end else if (s < 74) begin
            k  = K_SW;
            iw = {r[31:15], 3'b010, r[11:7], 7'b0100011};
        end else if (s < 88) begin
            k  = K_BEQ;
            op = 3'd1;
            iw = {r[31:15], 3'b000, r[11:7], 7'b1100011};
        end else if (s < 91) begin
            k  = K_ECALL;
            iw = 32'h0000_0073;
        end else begin
            k = K_ILL;
            case ($urandom_range(0, 7))
                0: begin
                    do o = 7'($urandom);
                    while (o inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h73});
                    iw = {r[31:7], o};
                end
                1: iw = {7'b0, r[24:15], 3'b011, r[11:7], 7'b0110011};
                2: begin
                    f3 = 3'($urandom_range(1, 7));
                    iw = {7'b0100000, r[24:15], f3, r[11:7], 7'b0110011};
                end
                3: iw = {r[31:15], 3'b011, r[11:7], 7'b0010011};
                4: iw = {7'b0100000, r[24:15], 3'b101, r[11:7], 7'b0010011};
                5: begin
                    f3 = 3'($urandom_range(0, 7));
                    if (f3 == 3'b010) f3 = 3'b011;
                    iw = {r[31:15], f3, r[11:7], 7'b0000011};
                end
                6: begin
                    f3 = 3'($urandom_range(0, 7));
                    if (f3 == 3'b010) f3 = 3'b000;
                    iw = {r[31:15], f3, r[11:7], 7'b0100011};
                end
                default: begin
                    f3 = 3'($urandom_range(1, 7));
                    iw = {r[31:15], f3, r[11:7], 7'b1100011};
                end
            endcase
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc_no);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] iw;
        kind_e       k;
        logic [2:0]  op;
        pl_e.delete(); pl_mr.delete(); pl_z.delete(); pl_rst.delete();
        reset_seq();
        play(32'h0);
        // directed: add, lw with 3 waits, beq taken/not taken, sra, ecall
        plan(K_R, 3'd0, 0, 0, 1'b0, -1);                play(32'h0020_8133);
        plan(K_LW, 3'd0, 0, 3, 1'b0, -1);               play(32'h0000_A103);
        plan(K_BEQ, 3'd1, 0, 0, 1'b1, -1);              play(32'h0020_8463);
        plan(K_BEQ, 3'd1, 0, 0, 1'b0, -1);              play(32'h0020_8463);
        plan(K_ILL, 3'd0, 0, 0, 1'b0, -1);              play(32'h4020_D133);
        plan(K_ECALL, 3'd0, 0, 0, 1'b0, -1);            play(32'h0000_0073);
        // fetch timeout, then ready on the limit cycle, then reset during sw MEM
        plan(K_R, 3'd0, int'(TO), 0, 1'b0, -1);         play(32'h0020_8133);
        plan(K_R, 3'd0, int'(TO) - 1, 0, 1'b0, -1);     play(32'h0020_8133);
        plan(K_SW, 3'd0, 0, 5, 1'b0, 5);                play(32'h0020_A223);
        plan(K_R, 3'd0, 0, 0, 1'b0, -1);                play(32'h0020_8133);
        for (int n = 0; n < 300; n++) begin
            gen(iw, k, op);
            plan(k, op, pick_wait(), pick_wait(), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 0 : -1);
            play(iw);
        end
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        checks++;
        if (exq.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected control words left, want 0", exq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
